// File: rtl/port_bus_arbiter_if.sv
// Port bus arbiter interface: two master request/done handshakes plus the
// shared I/O port bus (portaddr/portval/portget/portset/portout).
// The m0_lock/m1_lock inputs exist only when PORT_ARB_LOCK_EN is defined.
interface port_bus_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // master 0 (CPU)
  logic                 m0_req;
  logic                 m0_set;
  logic [WORD_SIZE-1:0] m0_addr;
  logic [WORD_SIZE-1:0] m0_val;
  logic                 m0_done;
  logic [WORD_SIZE-1:0] m0_rdata;

  // master 1 (DMA / debug monitor)
  logic                 m1_req;
  logic                 m1_set;
  logic [WORD_SIZE-1:0] m1_addr;
  logic [WORD_SIZE-1:0] m1_val;
  logic                 m1_done;
  logic [WORD_SIZE-1:0] m1_rdata;

`ifdef PORT_ARB_LOCK_EN
  logic                 m0_lock;
  logic                 m1_lock;
`endif

  // shared port bus
  logic [WORD_SIZE-1:0] portaddr;
  logic [WORD_SIZE-1:0] portval;
  logic                 portget;
  logic                 portset;
  logic [WORD_SIZE-1:0] portout;

  // debug view of the arbiter state
  logic [1:0]           arb_state;

  // arbiter side
  modport slave (
    input  m0_req, m0_set, m0_addr, m0_val,
    output m0_done, m0_rdata,
    input  m1_req, m1_set, m1_addr, m1_val,
    output m1_done, m1_rdata,
`ifdef PORT_ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    output portaddr, portval, portget, portset,
    input  portout,
    output arb_state
  );

  // master / port-device side
  modport master (
    output m0_req, m0_set, m0_addr, m0_val,
    input  m0_done, m0_rdata,
    output m1_req, m1_set, m1_addr, m1_val,
    input  m1_done, m1_rdata,
`ifdef PORT_ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    input  portaddr, portval, portget, portset,
    output portout,
    input  arb_state
  );
endinterface

// File: rtl/port_bus_arbiter.sv
// port_bus_arbiter: shares the single I/O port bus between master 0 (CPU)
// and master 1 (DMA / debug monitor). Each transaction is one grant edge,
// WAIT_CYCLES+1 access cycles with the strobe high, then a one-cycle done
// pulse. Ties are broken round-robin; master 0 wins the first tie.
// Define PORT_ARB_LOCK_EN to add m0_lock/m1_lock, which let a master keep
// exclusive ownership of the bus across consecutive transactions.
module port_bus_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  port_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t               state;
  logic                 grant;
  logic                 last_grant;
  logic                 lat_set;
  logic [3:0]           wait_cnt;

  // the bus output registers double as the latched address/data of the
  // granted master for the whole access phase
  logic [WORD_SIZE-1:0] port_addr_q;
  logic [WORD_SIZE-1:0] port_val_q;
  logic                 port_get_q;
  logic                 port_set_q;

  logic                 done0_q;
  logic                 done1_q;
  logic [WORD_SIZE-1:0] rdata0_q;
  logic [WORD_SIZE-1:0] rdata1_q;

  logic                 lock_active;
  logic                 lock_owner;

  logic                 owner_lock;
  logic                 granted_lock;
  logic                 lock_hold;
  logic                 any_req;
  logic                 pick;
  logic                 pick_set;
  logic [WORD_SIZE-1:0] pick_addr;
  logic [WORD_SIZE-1:0] pick_val;

`ifdef PORT_ARB_LOCK_EN
  // live lock input of the current lock owner and of the granted master
  always_comb begin
    owner_lock   = lock_owner ? bus.m1_lock : bus.m0_lock;
    granted_lock = grant ? bus.m1_lock : bus.m0_lock;
  end
`else
  assign owner_lock   = 1'b0;
  assign granted_lock = 1'b0;
`endif

  // arbitration decision used at IDLE edges: lock owner first, else round-robin
  always_comb begin
    lock_hold = lock_active && owner_lock;
    any_req   = 1'b0;
    pick      = 1'b0;
    if (lock_hold) begin
      pick    = lock_owner;
      any_req = lock_owner ? bus.m1_req : bus.m0_req;
    end else if (bus.m0_req && bus.m1_req) begin
      any_req = 1'b1;
      pick    = ~last_grant;
    end else if (bus.m0_req) begin
      any_req = 1'b1;
      pick    = 1'b0;
    end else if (bus.m1_req) begin
      any_req = 1'b1;
      pick    = 1'b1;
    end
    pick_set  = pick ? bus.m1_set  : bus.m0_set;
    pick_addr = pick ? bus.m1_addr : bus.m0_addr;
    pick_val  = pick ? bus.m1_val  : bus.m0_val;
  end

  // transaction FSM with all bus, done and rdata outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      lat_set     <= 1'b0;
      wait_cnt    <= '0;
      port_addr_q <= '0;
      port_val_q  <= '0;
      port_get_q  <= 1'b0;
      port_set_q  <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (lock_active && !owner_lock) begin
            lock_active <= 1'b0;
          end
          if (any_req) begin
            grant       <= pick;
            lat_set     <= pick_set;
            wait_cnt    <= WAIT_LOAD;
            port_addr_q <= pick_addr;
            port_val_q  <= pick_val;
            port_set_q  <= pick_set;
            port_get_q  <= ~pick_set;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            port_addr_q <= '0;
            port_val_q  <= '0;
            port_get_q  <= 1'b0;
            port_set_q  <= 1'b0;
            if (!lat_set) begin
              if (grant) begin
                rdata1_q <= bus.portout;
              end else begin
                rdata0_q <= bus.portout;
              end
            end
            if (grant) begin
              done1_q <= 1'b1;
            end else begin
              done0_q <= 1'b1;
            end
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          last_grant  <= grant;
          lock_active <= granted_lock;
          lock_owner  <= grant;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.portaddr  = port_addr_q;
  assign bus.portval   = port_val_q;
  assign bus.portget   = port_get_q;
  assign bus.portset   = port_set_q;
  assign bus.m0_done   = done0_q;
  assign bus.m1_done   = done1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.arb_state = state;

endmodule

// File: doc/port_bus_arbiter.md
Name: port_bus_arbiter

Overview:
- Shares the single I/O port bus (portaddr/portval/portget/portset/portout) between two bus masters.
- Master 0 is the CPU; master 1 is a DMA or debug monitor.
- Each transaction is sequenced as one grant cycle, a programmable number of access cycles, and a one-cycle done pulse.
- Sits between `cpu`/auxiliary master and `ports` inside `main`.

Parameters:
- WORD_SIZE, 16, width of port address and data.
- WAIT_CYCLES, 1, extra access cycles the port device needs; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous reset, active-low.
- m0_req  input  1  master 0 requests a transaction; level, held until m0_done.
- m0_set  input  1  1 = write (portset), 0 = read (portget).
- m0_addr  input  WORD_SIZE  port address.
- m0_val  input  WORD_SIZE  write data.
- m0_done  output  1  one-cycle completion pulse.
- m0_rdata  output  WORD_SIZE  read data, valid from m0_done onward.
- m1_req, m1_set, m1_addr, m1_val, m1_done, m1_rdata: same as master 0, for master 1.
- portaddr  output  WORD_SIZE  address to ports.
- portval  output  WORD_SIZE  write data to ports.
- portget  output  1  read strobe.
- portset  output  1  write strobe.
- portout  input  WORD_SIZE  read data from ports.
- arb_state  output  2  current state, for debug: 0 = IDLE, 1 = ACCESS, 2 = DONE.

Behaviour:
- Reset (rst_n low, takes effect immediately, mid-transaction included):
  - state = IDLE.
  - portget = portset = 0; portaddr = portval = 0.
  - m0_done = m1_done = 0; m0_rdata = m1_rdata = 0.
  - Round-robin pointer set so master 0 wins the first tie.
  - Any in-flight transaction is abandoned; no done pulse.
- All outputs are registered. Bus outputs are driven only in ACCESS; they are 0 in IDLE and DONE.
- IDLE:
  - Sample m0_req/m1_req at the clock edge.
  - Only one requesting: grant it.
  - Both requesting: grant the master not granted last.
  - On grant: latch addr, val and set into internal registers; load wait counter with WAIT_CYCLES; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - portaddr/portval = latched values; portset = latched set; portget = !latched set.
  - Lasts exactly WAIT_CYCLES+1 cycles; the counter decrements each cycle.
  - Leaving on counter == 0 moves to DONE. On a read, portout is captured into the granted master's rdata at that same edge.
  - Changes on the master's inputs during ACCESS are ignored, including req dropping; the transaction always completes.
- DONE:
  - The granted master's done = 1 for exactly one cycle; the other master's done stays 0.
  - Round-robin pointer records the granted master; next state is IDLE.
- Timing: req first sampled high at edge N (in IDLE) → strobes high in cycles N+1 .. N+1+WAIT_CYCLES → done high in cycle N+2+WAIT_CYCLES.
  - Minimum transaction period is WAIT_CYCLES+3 cycles.
- Handshake:
  - A master drops req in the cycle after seeing done.
  - If req is still high in the following IDLE cycle, that is a new transaction; it is subject to round-robin.
  - With both masters requesting continuously, grants alternate strictly 0,1,0,1…
- rdata holds its value until that master's next read completes; writes never change rdata.
- portget and portset are never both 1, and never 1 outside ACCESS.

Optional Feature:
- Macro PORT_ARB_LOCK_EN.
- When defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If the granted master's lock is high at the DONE edge, the arbiter enters a locked condition for that master.
  - While locked, the other master is never granted; the owner is granted whenever it requests.
  - The lock clears in IDLE when the owner's lock is sampled low; reset also clears it.
  - Lock inputs are ignored outside DONE/IDLE.
- When undefined: no lock ports, pure round-robin as above.

Test Plan:
- Reset then m0 read, addr=0x0010, portout=0xBEEF, WAIT_CYCLES=1 → portget high for 2 cycles with portaddr=0x0010; m0_done pulses one cycle later; m0_rdata=0xBEEF; m1_rdata=0.
- m1 write, addr=0x0003, val=0x1234 → portset high for WAIT_CYCLES+1 cycles with portval=0x1234; portget stays 0; m1_done single pulse; m1_rdata unchanged.
- m0 and m1 both request from reset and hold req continuously → grant order 0,1,0,1; each done pulse spaced WAIT_CYCLES+3 cycles apart.
- rst_n pulled low during ACCESS → strobes drop to 0 asynchronously (before the next clk edge); no done pulse; arb_state=0; next grant goes to m0.
- WAIT_CYCLES=0, single m0 read → strobe high for exactly 1 cycle; done 2 cycles after the grant edge.
- With PORT_ARB_LOCK_EN: m0_lock=1 across 3 transactions while m1_req held high → m1 is not granted until m0_lock=0 is sampled in IDLE; m1 is then granted next.
